pe_result_drain: RTL

//   Write-side counterpart to the PE's file-initialised data load. After a sort
//   or compute pass, it captures the word stream from a PE's o_PE output.

---
 rtl/pe_result_drain.sv | 117 +++++++++++
 1 files changed

// File: rtl/pe_result_drain.sv
// Captures a fixed-length word stream from a PE after a settle delay.
// The words are then drained downstream with address tags over a valid/ready port.
module pe_result_drain #(
   parameter int unsigned N             = 4,
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_PE,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CW    = $clog2(SETTLE_CYCLES + 2);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      DRAIN,
      DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_next;
   logic [CW-1:0]         settle_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rd_next = rd_ptr + ADDR_WIDTH'(1);

   // Buffer storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst && state == CAPTURE) begin
         mem[wr_ptr] <= i_PE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         o_data     <= '0;
         o_addr     <= '0;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_busy <= 1'b1;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  if (SETTLE_CYCLES != 0) begin
                     state      <= SETTLE;
                     settle_cnt <= CW'(SETTLE_CYCLES);
                  end else begin
                     state <= CAPTURE;
                  end
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - CW'(1);
               if (settle_cnt == CW'(1)) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (wr_ptr == LAST) begin
                  // Word 0 is still being written when N==1, so take it from the input.
                  o_data  <= (N == 1) ? i_PE : mem[0];
                  o_addr  <= '0;
                  o_valid <= 1'b1;
                  state   <= DRAIN;
               end else begin
                  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (o_valid && i_ready) begin
                  if (rd_ptr == LAST) begin
                     o_valid <= 1'b0;
                     o_done  <= 1'b1;
                     state   <= DONE;
                  end else begin
                     rd_ptr <= rd_next;
                     o_addr <= rd_next;
                     o_data <= mem[rd_next];
                  end
               end
            end
            DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               wr_ptr <= '0;
               rd_ptr <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
